// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader and the sequencer load chain.
// Holds the header layout and its unpack helper, the loader state encoding and the default widths.
package instr_loader_pkg;

   localparam int INSTR_DATA_WIDTH_DEF = 32;
   localparam int INSTR_ADDR_WIDTH_DEF = 6;
   localparam int INSTR_HOPS_WIDTH_DEF = 4;

   localparam int SEQ_NUM_SEQUENCERS = 1 << INSTR_HOPS_WIDTH_DEF;
   localparam int SEQ_IRAM_DEPTH     = 1 << INSTR_ADDR_WIDTH_DEF;

   typedef struct packed {
      logic [3:0] hops;
      logic [5:0] base;
      logic [5:0] cnt_m1;
      logic       start;
   } instr_hdr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALL = 2'd2,
      RUN  = 2'd3
   } ld_state_t;

   // Takes header bits [31:15]; the remaining low bits carry no meaning.
   function automatic instr_hdr_t unpack_hdr(input logic [16:0] hi);
      instr_hdr_t h;
      h.hops   = hi[16:13];
      h.base   = hi[12:7];
      h.cnt_m1 = hi[6:1];
      h.start  = hi[0];
      return h;
   endfunction

endpackage

// File: rtl/instr_loader_load_chain_reg.sv
// Output register stage of the instruction load chain.
// Data, address and hops are forced to zero in any cycle without a strobe.
import instr_loader_pkg::*;

module load_chain_reg #(
   parameter int DATA_WIDTH = INSTR_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = INSTR_ADDR_WIDTH_DEF,
   parameter int HOPS_WIDTH = INSTR_HOPS_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [HOPS_WIDTH-1:0] i_hops,
   output logic                  o_en,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [HOPS_WIDTH-1:0] o_hops
);

   logic                  r_en;
   logic [DATA_WIDTH-1:0] r_data;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [HOPS_WIDTH-1:0] r_hops;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en   <= 1'b0;
         r_data <= '0;
         r_addr <= '0;
         r_hops <= '0;
      end else begin
         r_en   <= i_en;
         r_data <= i_en ? i_data : '0;
         r_addr <= i_en ? i_addr : '0;
         r_hops <= i_en ? i_hops : '0;
      end
   end

   assign o_en   = r_en;
   assign o_data = r_data;
   assign o_addr = r_addr;
   assign o_hops = r_hops;

endmodule

// File: rtl/instr_loader.sv
// Streams a header-described packet of instruction words onto the sequencer load chain,
// then optionally starts the sequencers and waits for their return pulse.
import instr_loader_pkg::*;

module instr_loader #(
   parameter int INSTR_DATA_WIDTH = INSTR_DATA_WIDTH_DEF,
   parameter int INSTR_ADDR_WIDTH = INSTR_ADDR_WIDTH_DEF,
   parameter int INSTR_HOPS_WIDTH = INSTR_HOPS_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [INSTR_DATA_WIDTH-1:0] s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic [INSTR_DATA_WIDTH-1:0] instr_load_data_out,
   output logic [INSTR_ADDR_WIDTH-1:0] instr_load_addr_out,
   output logic [INSTR_HOPS_WIDTH-1:0] instr_load_hops_out,
   output logic                        instr_load_en_out,
   output logic                        call,
   input  logic                        ret,
   output logic                        busy,
   output logic [INSTR_ADDR_WIDTH:0]   words_loaded
);

   ld_state_t                   r_state;
   ld_state_t                   w_state_next;
   logic [INSTR_HOPS_WIDTH-1:0] r_hops;
   logic [INSTR_ADDR_WIDTH-1:0] r_base;
   logic [INSTR_ADDR_WIDTH-1:0] r_cnt_m1;
   logic                        r_start;
   logic [INSTR_ADDR_WIDTH:0]   r_words;
   logic                        r_call;

   instr_hdr_t                  w_hdr;
   logic                        w_ready;
   logic                        w_xfer;
   logic                        w_emit;
   logic                        w_last;
   logic [INSTR_ADDR_WIDTH-1:0] w_addr;

   assign w_hdr  = unpack_hdr(s_data[31:15]);
   assign w_xfer = s_valid && w_ready;
   assign w_emit = w_xfer && (r_state == LOAD);
   assign w_last = (r_words[INSTR_ADDR_WIDTH-1:0] == r_cnt_m1);
   // Address wraps naturally in the iram address width.
   assign w_addr = r_base + r_words[INSTR_ADDR_WIDTH-1:0];

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (w_xfer) w_state_next = LOAD;
         end
         LOAD: begin
            w_ready = 1'b1;
            if (w_xfer && w_last) w_state_next = r_start ? CALL : IDLE;
         end
         CALL: w_state_next = RUN;
         RUN: begin
            if (ret) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_hops   <= '0;
         r_base   <= '0;
         r_cnt_m1 <= '0;
         r_start  <= 1'b0;
         r_words  <= '0;
         r_call   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // The pulse lands one cycle after CALL so it never overlaps the final strobe.
         r_call  <= (r_state == CALL);
         if (w_xfer && (r_state == IDLE)) begin
            r_hops   <= w_hdr.hops;
            r_base   <= w_hdr.base;
            r_cnt_m1 <= w_hdr.cnt_m1;
            r_start  <= w_hdr.start;
            r_words  <= '0;
         end else if (w_emit) begin
            r_words <= r_words + 1'b1;
         end
      end
   end

   load_chain_reg #(
      .DATA_WIDTH (INSTR_DATA_WIDTH),
      .ADDR_WIDTH (INSTR_ADDR_WIDTH),
      .HOPS_WIDTH (INSTR_HOPS_WIDTH)
   ) u_chain (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_emit),
      .i_data (s_data),
      .i_addr (w_addr),
      .i_hops (r_hops),
      .o_en   (instr_load_en_out),
      .o_data (instr_load_data_out),
      .o_addr (instr_load_addr_out),
      .o_hops (instr_load_hops_out)
   );

   assign s_ready      = w_ready;
   assign call         = r_call;
   assign busy         = (r_state != IDLE);
   assign words_loaded = r_words;

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized bench for instr_loader; expected load-chain traffic is
// derived from the header fields with plain arithmetic.
`timescale 1ns/1ps

module tb_instr_loader;

   logic        clk;
   logic        rst_n;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] data_out;
   logic [5:0]  addr_out;
   logic [3:0]  hops_out;
   logic        en_out;
   logic        call;
   logic        ret;
   logic        busy;
   logic [6:0]  words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   instr_loader dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .s_data              (s_data),
      .s_valid             (s_valid),
      .s_ready             (s_ready),
      .instr_load_data_out (data_out),
      .instr_load_addr_out (addr_out),
      .instr_load_hops_out (hops_out),
      .instr_load_en_out   (en_out),
      .call                (call),
      .ret                 (ret),
      .busy                (busy),
      .words_loaded        (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en"},    en_out, 0);
      check({tag, "_data"},  data_out, 0);
      check({tag, "_addr"},  addr_out, 0);
      check({tag, "_hops"},  hops_out, 0);
      check({tag, "_call"},  call, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_wl"},    words_loaded, 0);
   endtask

   function automatic logic [31:0] make_hdr(input int hops, input int base, input int cnt, input bit start);
      logic [3:0]  h4;
      logic [5:0]  b6;
      logic [5:0]  c6;
      logic [14:0] junk;
      h4   = 4'(hops);
      b6   = 6'(base);
      c6   = 6'(cnt - 1);
      junk = 15'($urandom);
      return {h4, b6, c6, start, junk};
   endfunction

   // Sends one full packet and checks every resulting cycle against the header rules.
   task automatic send_packet(input int hops, input int base, input int cnt, input bit start,
                              input int gap_idx, input int gap_len, input bit rnd_gaps,
                              input bit ret_in_load, input int ret_delay);
      int nb;
      logic [31:0] w;
      s_data  = make_hdr(hops, base, cnt, start);
      s_valid = 1'b1;
      ret     = ret_in_load;
      check("hdr_ready", s_ready, 1);
      @(posedge clk); #1;
      check("hdr_busy", busy, 1);
      check("hdr_wl", words_loaded, 0);
      check("hdr_en", en_out, 0);
      for (int i = 0; i < cnt; i++) begin
         nb = (i == gap_idx) ? gap_len : ((rnd_gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
         for (int b = 0; b < nb; b++) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            ret     = ret_in_load;
            @(posedge clk); #1;
            check("gap_en", en_out, 0);
            check("gap_data", data_out, 0);
            check("gap_addr", addr_out, 0);
            check("gap_busy", busy, 1);
         end
         w       = $urandom;
         s_valid = 1'b1;
         s_data  = w;
         ret     = ret_in_load;
         check("ld_ready", s_ready, 1);
         @(posedge clk); #1;
         check("ld_en", en_out, 1);
         check("ld_data", data_out, w);
         check("ld_addr", addr_out, (base + i) % 64);
         check("ld_hops", hops_out, hops);
         check("ld_wl", words_loaded, i + 1);
         check("ld_call", call, 0);
      end
      s_valid = 1'b0;
      ret     = 1'b0;
      if (!start) begin
         check("end_busy", busy, 0);
         check("end_ready", s_ready, 1);
         check("end_call", call, 0);
      end else begin
         check("call_busy", busy, 1);
         check("call_ready", s_ready, 0);
         check("call_early", call, 0);
         s_valid = 1'b1;
         s_data  = $urandom;
         @(posedge clk); #1;
         check("call_pulse", call, 1);
         check("call_en", en_out, 0);
         check("call_ready2", s_ready, 0);
         for (int k = 0; k < ret_delay; k++) begin
            s_valid = $urandom_range(0, 1);
            s_data  = $urandom;
            @(posedge clk); #1;
            check("run_call", call, 0);
            check("run_busy", busy, 1);
            check("run_ready", s_ready, 0);
            check("run_en", en_out, 0);
         end
         s_valid = 1'b0;
         ret     = 1'b1;
         @(posedge clk); #1;
         ret = 1'b0;
         check("ret_busy", busy, 0);
         check("ret_ready", s_ready, 1);
         check("ret_call", call, 0);
      end
   endtask

   initial begin
      logic [31:0] w;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      ret     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", s_ready, 1);
      check("rst_busy", busy, 0);

      // Three words back-to-back, no start.
      send_packet(0, 0, 3, 1'b0, -1, 0, 1'b0, 1'b0, 0);
      // Address wrap with non-zero hops.
      send_packet(2, 62, 4, 1'b0, -1, 0, 1'b0, 1'b0, 0);
      // Two-cycle stall mid-packet.
      send_packet(5, 10, 5, 1'b0, 2, 2, 1'b0, 1'b0, 0);
      // Single word with start, return after 10 cycles.
      send_packet(7, 20, 1, 1'b1, -1, 0, 1'b0, 1'b0, 10);

      // ret in IDLE and during LOAD must not disturb anything.
      ret = 1'b1;
      @(posedge clk); #1;
      ret = 1'b0;
      check("ret_idle_busy", busy, 0);
      check("ret_idle_ready", s_ready, 1);
      check("ret_idle_call", call, 0);
      send_packet(3, 33, 4, 1'b0, 1, 1, 1'b0, 1'b1, 0);

      // Reset after 2 of 5 words.
      s_data  = make_hdr(9, 40, 5, 1'b1);
      s_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         w      = $urandom;
         s_data = w;
         @(posedge clk); #1;
         check("prerst_en", en_out, 1);
         check("prerst_addr", addr_out, 40 + i);
      end
      s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("postrst_ready", s_ready, 1);
      send_packet(1, 5, 3, 1'b0, -1, 0, 1'b0, 1'b0, 0);

      // Maximum packet: 64 words with wrap, then start.
      send_packet(15, 17, 64, 1'b1, -1, 0, 1'b1, 1'b0, 3);

      for (int p = 0; p < 12; p++) begin
         send_packet($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(1, 64),
                     1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 6));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check("idle_en", en_out, 0);
            check("idle_busy", busy, 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
